// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel output stage (pixel clock domain).
// Stage 0 holds the h/v raster counters and decodes fetch/strobe outputs from them.
// Stage 1 delays sync/active by one cycle while the pixel source returns RGB.
// Stage 2 registers the VGA-style outputs, all mutually aligned.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_pixel,
  input  logic          reset_i,
  output logic          pix_req_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  input  logic [23:0]   rgb_i,
  output logic          frame_start_o,
  output logic          line_start_o,
  output logic          vblank_o,
  output logic          vga_hsync_o,
  output logic          vga_vsync_o,
  output logic          vga_blank_o,
  output logic [7:0]    vga_r_o,
  output logic [7:0]    vga_g_o,
  output logic [7:0]    vga_b_o
);

  // Region boundaries carry one spare bit so an end boundary equal to the
  // total (zero back porch with a power-of-two total) still fits.
  localparam logic [HW:0] H_LAST     = (HW+1)'(H_TOTAL - 1);
  localparam logic [HW:0] H_ACT_END  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_START   = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END     = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_LAST     = (VW+1)'(V_TOTAL - 1);
  localparam logic [VW:0] V_ACT_END  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_START   = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END     = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;
  logic          h_last;
  logic          v_last;
  logic          h_active;
  logic          v_active;
  logic          active;
  logic          hsync;
  logic          vsync;

  logic          hsync_p1;
  logic          vsync_p1;
  logic          active_p1;

  // Stage 0: raster counters; v advances only on the h wrap.
  always_ff @(posedge clk_pixel) begin
    if (reset_i) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Stage 0 decode: region flags and the unconditionally valid fetch/strobe outputs.
  always_comb begin
    h_ext    = {1'b0, h};
    v_ext    = {1'b0, v};
    h_last   = (h_ext == H_LAST);
    v_last   = (v_ext == V_LAST);
    h_active = (h_ext < H_ACT_END);
    v_active = (v_ext < V_ACT_END);
    active   = h_active & v_active;
    hsync    = (h_ext >= HS_START) && (h_ext < HS_END);
    // vsync is a pure function of v, so it can only change where h wraps to 0.
    vsync    = (v_ext >= VS_START) && (v_ext < VS_END);

    x_o           = h;
    y_o           = v;
    vblank_o      = ~v_active;
    // Strobes are held off during reset so the restart pulse is the first one seen.
    pix_req_o     = active & ~reset_i;
    frame_start_o = (h == '0) && (v == '0) && ~reset_i;
    line_start_o  = (h == '0) && v_active && ~reset_i;
  end

  // Stage 1: delay sync/active one cycle while the pixel source answers the request.
  always_ff @(posedge clk_pixel) begin
    if (reset_i) begin
      hsync_p1  <= 1'b0;
      vsync_p1  <= 1'b0;
      active_p1 <= 1'b0;
    end else begin
      hsync_p1  <= hsync;
      vsync_p1  <= vsync;
      active_p1 <= active;
    end
  end

  // Stage 2: output registers; polarity applied here, RGB forced to black outside active.
  always_ff @(posedge clk_pixel) begin
    if (reset_i) begin
      vga_hsync_o <= ~HSYNC_POL;
      vga_vsync_o <= ~VSYNC_POL;
      vga_blank_o <= 1'b1;
      vga_r_o     <= '0;
      vga_g_o     <= '0;
      vga_b_o     <= '0;
    end else begin
      vga_hsync_o <= hsync_p1 ~^ HSYNC_POL;
      vga_vsync_o <= vsync_p1 ~^ VSYNC_POL;
      vga_blank_o <= ~active_p1;
      {vga_r_o, vga_g_o, vga_b_o} <= active_p1 ? rgb_i : 24'h0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-timing instance checked against a
// cycle model with an output scoreboard, plus a tiny-raster instance with
// active-high syncs for frame-level behaviour.
module tb_video_timing_gen;

  localparam int HW  = 10;
  localparam int VW  = 10;
  localparam int HT  = 800;
  localparam int VT  = 525;
  localparam int HA  = 640;
  localparam int VA  = 480;
  localparam int HS0 = 656;
  localparam int HS1 = 752;
  localparam int VS0 = 490;
  localparam int VS1 = 492;
  localparam logic [26:0] RST_VGA = {1'b1, 1'b1, 1'b1, 24'h0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-timing instance
  logic          reset_i = 1'b1;
  logic [23:0]   rgb_i = 24'h0;
  logic          pix_req_o, frame_start_o, line_start_o, vblank_o;
  logic [HW-1:0] x_o;
  logic [VW-1:0] y_o;
  logic          vga_hsync_o, vga_vsync_o, vga_blank_o;
  logic [7:0]    vga_r_o, vga_g_o, vga_b_o;

  video_timing_gen dut (
    .clk_pixel(clk), .reset_i(reset_i), .pix_req_o(pix_req_o), .x_o(x_o), .y_o(y_o),
    .rgb_i(rgb_i), .frame_start_o(frame_start_o), .line_start_o(line_start_o),
    .vblank_o(vblank_o), .vga_hsync_o(vga_hsync_o), .vga_vsync_o(vga_vsync_o),
    .vga_blank_o(vga_blank_o), .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o)
  );

  // small-raster instance: H 4/1/1/1, V 3/1/1/1, active-high syncs
  logic        reset_s = 1'b1;
  logic [23:0] rgb_s = 24'h5A5A5A;
  logic        req_s, fs_s, ls_s, vb_s;
  logic [2:0]  x_s, y_s;
  logic        hs_s, vs_s, bl_s;
  logic [7:0]  r_s, g_s, b_s;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_s (
    .clk_pixel(clk), .reset_i(reset_s), .pix_req_o(req_s), .x_o(x_s), .y_o(y_s),
    .rgb_i(rgb_s), .frame_start_o(fs_s), .line_start_o(ls_s), .vblank_o(vb_s),
    .vga_hsync_o(hs_s), .vga_vsync_o(vs_s), .vga_blank_o(bl_s),
    .vga_r_o(r_s), .vga_g_o(g_s), .vga_b_o(b_s)
  );

  wire [HW+VW+3:0] s0  = {x_o, y_o, pix_req_o, frame_start_o, line_start_o, vblank_o};
  wire [26:0]      vga = {vga_hsync_o, vga_vsync_o, vga_blank_o, vga_r_o, vga_g_o, vga_b_o};

  int checks = 0;
  int errors = 0;

  // model state and scoreboard
  logic [26:0]     sbq[$];
  int              mh = 0;
  int              mv = 0;
  bit              prev_req = 1'b0;
  int              prev_x = 0;
  int              prev_y = 0;
  logic [HW+VW+3:0] exp_s0;
  logic [26:0]     exp_vga;
  bit              vga_ok;

  // Advance one cycle: drive reset and the pixel-source reply, predict stage-0
  // outputs for this cycle, pop the expected output word, push this pixel's word.
  task automatic step(input bit rst);
    logic [26:0] e;
    bit act, hs, vs, req;
    @(posedge clk);
    #1;
    reset_i = rst;
    rgb_i = prev_req ? {8'(prev_x), 8'(prev_y), 8'hA5} : 24'($urandom);
    act = (mh < HA) && (mv < VA);
    req = act && !rst;
    exp_s0 = {HW'(mh), VW'(mv), req, (mh == 0) && (mv == 0) && !rst,
              (mh == 0) && (mv < VA) && !rst, mv >= VA};
    vga_ok = (sbq.size() > 0);
    if (vga_ok) exp_vga = sbq.pop_front();
    prev_req = req;
    prev_x = mh;
    prev_y = mv;
    if (rst) begin
      sbq.delete();
      sbq.push_back(RST_VGA);
      sbq.push_back(RST_VGA);
      mh = 0;
      mv = 0;
    end else begin
      hs = (mh >= HS0) && (mh < HS1);
      vs = (mv >= VS0) && (mv < VS1);
      e = {~hs, ~vs, ~act, act ? {8'(mh), 8'(mv), 8'hA5} : 24'h0};
      sbq.push_back(e);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      if (i > 0) begin
        checks++;
        if (s0 !== exp_s0) begin
          errors++;
          $display("FAIL reset_s0 cyc %0d got %h exp %h", i, s0, exp_s0);
        end
        checks++;
        if (vga !== RST_VGA) begin
          errors++;
          $display("FAIL reset_vga cyc %0d got %h exp %h", i, vga, RST_VGA);
        end
      end
    end
    step(1'b0);
    checks++;
    if ({frame_start_o, pix_req_o, x_o, y_o} !== {1'b1, 1'b1, HW'(0), VW'(0)}) begin
      errors++;
      $display("FAIL release_frame_start got fs=%b req=%b x=%0d y=%0d exp fs=1 req=1 x=0 y=0",
               frame_start_o, pix_req_o, x_o, y_o);
    end
    checks++;
    if (vga_ok && vga !== exp_vga) begin
      errors++;
      $display("FAIL release_vga got %h exp %h", vga, exp_vga);
    end
  endtask

  task automatic test_line_timing();
    bit hs_prev = 1'b1;
    bit bl_prev = 1'b1;
    int fall_cyc = -1;
    int falls = 0;
    int low_run = 0;
    int blank_run = 0;
    int blank_rises = 0;
    logic [HW-1:0] xh1 = '0;
    logic [HW-1:0] xh2 = '0;
    for (int i = 0; i < 1700; i++) begin
      step(1'b0);
      checks++;
      if (s0 !== exp_s0) begin
        errors++;
        $display("FAIL line_s0 cyc %0d got %h exp %h", i, s0, exp_s0);
      end
      if (vga_ok) begin
        checks++;
        if (vga !== exp_vga) begin
          errors++;
          $display("FAIL line_vga cyc %0d got %h exp %h", i, vga, exp_vga);
        end
      end
      if (hs_prev && !vga_hsync_o) begin
        checks++;
        if (xh2 !== HW'(HS0)) begin
          errors++;
          $display("FAIL hsync_fall_x got %0d exp %0d", xh2, HS0);
        end
        if (fall_cyc >= 0) begin
          checks++;
          if (i - fall_cyc != HT) begin
            errors++;
            $display("FAIL hsync_period got %0d exp %0d", i - fall_cyc, HT);
          end
        end
        fall_cyc = i;
        falls++;
      end
      if (!hs_prev && vga_hsync_o) begin
        checks++;
        if (low_run != HS1 - HS0) begin
          errors++;
          $display("FAIL hsync_low_width got %0d exp %0d", low_run, HS1 - HS0);
        end
        low_run = 0;
      end
      if (!vga_hsync_o) low_run++;
      if (!bl_prev && vga_blank_o) begin
        checks++;
        if (blank_run != HA) begin
          errors++;
          $display("FAIL blank_low_run got %0d exp %0d", blank_run, HA);
        end
        blank_run = 0;
        blank_rises++;
      end
      if (!vga_blank_o) blank_run++;
      hs_prev = vga_hsync_o;
      bl_prev = vga_blank_o;
      xh2 = xh1;
      xh1 = x_o;
    end
    checks++;
    if (falls != 2 || blank_rises != 2) begin
      errors++;
      $display("FAIL line_event_count got falls=%0d blank_rises=%0d exp 2 and 2", falls, blank_rises);
    end
  endtask

  task automatic test_data_alignment();
    int active_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      step(1'b0);
      if (vga_ok) begin
        checks++;
        if (vga !== exp_vga) begin
          errors++;
          $display("FAIL align_vga cyc %0d got %h exp %h", i, vga, exp_vga);
        end
      end
      checks++;
      if (vga_blank_o && {vga_r_o, vga_g_o, vga_b_o} !== 24'h0) begin
        errors++;
        $display("FAIL blank_rgb cyc %0d got %h exp 000000", i, {vga_r_o, vga_g_o, vga_b_o});
      end
      if (!vga_blank_o) active_cnt++;
    end
    checks++;
    if (active_cnt != HA) begin
      errors++;
      $display("FAIL active_per_line got %0d exp %0d", active_cnt, HA);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (!(mh == 300 && mv == 4) && n < 3000) begin
      step(1'b0);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL mid_reset_reach got h=%0d v=%0d exp h=300 v=4", mh, mv);
    end
    step(1'b1);
    checks++;
    if (s0 !== exp_s0) begin
      errors++;
      $display("FAIL mid_reset_s0 got %h exp %h", s0, exp_s0);
    end
    step(1'b0);
    checks++;
    if (vga !== RST_VGA || {frame_start_o, x_o, y_o} !== {1'b1, HW'(0), VW'(0)}) begin
      errors++;
      $display("FAIL mid_reset_restart got vga=%h fs=%b x=%0d y=%0d exp vga=%h fs=1 x=0 y=0",
               vga, frame_start_o, x_o, y_o, RST_VGA);
    end
    step(1'b0);
    step(1'b0);
    checks++;
    if (vga !== {1'b1, 1'b1, 1'b0, 24'h0000A5}) begin
      errors++;
      $display("FAIL mid_reset_first_pixel got %h exp %h", vga, {1'b1, 1'b1, 1'b0, 24'h0000A5});
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      checks++;
      if (s0 !== exp_s0 || (vga_ok && vga !== exp_vga)) begin
        errors++;
        $display("FAIL mid_reset_run cyc %0d got %h/%h exp %h/%h", i, s0, vga, exp_s0, exp_vga);
      end
    end
  endtask

  task automatic test_small_config();
    int sh = 0;
    int sv = 0;
    int fs_cnt = 0;
    int ls_cnt = 0;
    int hs_hi = 0;
    int vs_hi = 0;
    bit act;
    logic [2:0] d1 = 3'b000;
    logic [2:0] d2 = 3'b000;
    logic [9:0] e0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      reset_s = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({hs_s, vs_s, bl_s, req_s, fs_s, x_s, y_s} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL small_reset got hs=%b vs=%b bl=%b req=%b fs=%b x=%0d y=%0d",
               hs_s, vs_s, bl_s, req_s, fs_s, x_s, y_s);
    end
    for (int i = 0; i < 84; i++) begin
      @(posedge clk);
      #1;
      reset_s = 1'b0;
      @(negedge clk);
      act = (sh < 4) && (sv < 3);
      e0 = {3'(sh), 3'(sv), act, (sh == 0) && (sv == 0), (sh == 0) && (sv < 3), sv >= 3};
      checks++;
      if ({x_s, y_s, req_s, fs_s, ls_s, vb_s} !== e0) begin
        errors++;
        $display("FAIL small_s0 cyc %0d got %h exp %h", i, {x_s, y_s, req_s, fs_s, ls_s, vb_s}, e0);
      end
      checks++;
      if ({hs_s, vs_s, bl_s} !== {d2[2], d2[1], ~d2[0]}) begin
        errors++;
        $display("FAIL small_vga cyc %0d got %b exp %b", i, {hs_s, vs_s, bl_s}, {d2[2], d2[1], ~d2[0]});
      end
      checks++;
      if ({r_s, g_s, b_s} !== (bl_s ? 24'h0 : 24'h5A5A5A)) begin
        errors++;
        $display("FAIL small_rgb cyc %0d got %h blank=%b", i, {r_s, g_s, b_s}, bl_s);
      end
      fs_cnt += int'(fs_s);
      ls_cnt += int'(ls_s);
      hs_hi  += int'(hs_s);
      vs_hi  += int'(vs_s);
      d2 = d1;
      d1 = {sh == 5, sv == 4, act};
      if (sh == 6) begin
        sh = 0;
        sv = (sv == 5) ? 0 : sv + 1;
      end else begin
        sh++;
      end
    end
    checks++;
    if (fs_cnt != 2 || ls_cnt != 6) begin
      errors++;
      $display("FAIL small_strobe_counts got fs=%0d ls=%0d exp fs=2 ls=6", fs_cnt, ls_cnt);
    end
    checks++;
    if (hs_hi != 11 || vs_hi != 14) begin
      errors++;
      $display("FAIL small_sync_counts got hs=%0d vs=%0d exp hs=11 vs=14", hs_hi, vs_hi);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_data_alignment();
    test_mid_reset();
    test_small_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
